// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point helpers for the neural network accelerator datapath:
// default Q-format widths, saturation limits and the saturate/ReLU stage.
package nn_fixed_pkg;

    localparam int unsigned NN_DATA_W = 8;
    localparam int unsigned NN_FRAC_W = 6;

    // Control states of the dot-product engine
    typedef enum logic [2:0] {
        ST_ACCUM,
        ST_DRAIN,
        ST_FLUSH1,
        ST_FLUSH2,
        ST_OUT
    } mac_state_t;

    // Post-processed value plus a flag telling whether saturation clamped it
    typedef struct packed {
        logic               sat;
        logic signed [63:0] value;
    } sat_result_t;

    // Largest representable value of a data_w-bit two's complement number
    function automatic logic signed [63:0] q_max(input int unsigned data_w);
        return (64'sd1 <<< (data_w - 1)) - 64'sd1;
    endfunction

    // Smallest representable value of a data_w-bit two's complement number
    function automatic logic signed [63:0] q_min(input int unsigned data_w);
        return -(64'sd1 <<< (data_w - 1));
    endfunction

    // Optional ReLU followed by saturation; only the saturation step sets sat
    function automatic sat_result_t sat_relu(input logic signed [63:0] v,
                                             input logic               relu,
                                             input int unsigned        data_w);
        sat_result_t r;
        r.sat   = 1'b0;
        r.value = v;
        if (relu && (v < 64'sd0)) begin
            r.value = '0;
        end else if (v > q_max(data_w)) begin
            r.value = q_max(data_w);
            r.sat   = 1'b1;
        end else if (v < q_min(data_w)) begin
            r.value = q_min(data_w);
            r.sat   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_lane_tree.sv
// LANES signed multipliers with a registered product stage, followed by a
// combinational adder tree that sign-extends every product to ACC_W.
module mac_lane_tree
    import nn_fixed_pkg::*;
#(
    parameter int unsigned DATA_W = NN_DATA_W,
    parameter int unsigned LANES  = 4,
    parameter int unsigned ACC_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic                      in_first,
    input  logic [LANES*DATA_W-1:0]   a,
    input  logic [LANES*DATA_W-1:0]   b,
    output logic                      out_valid,
    output logic                      out_first,
    output logic signed [ACC_W-1:0]   sum
);

    logic signed [2*DATA_W-1:0] a_ext [LANES];
    logic signed [2*DATA_W-1:0] b_ext [LANES];
    logic signed [2*DATA_W-1:0] prod  [LANES];

    // Widen each lane operand so the product is formed at full precision
    always_comb begin
        for (int i = 0; i < int'(LANES); i++) begin
            a_ext[i] = {{DATA_W{a[i*DATA_W+DATA_W-1]}}, a[i*DATA_W +: DATA_W]};
            b_ext[i] = {{DATA_W{b[i*DATA_W+DATA_W-1]}}, b[i*DATA_W +: DATA_W]};
        end
    end

    // Stage-1 register: products only load on an accepted beat
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            for (int i = 0; i < int'(LANES); i++) begin
                prod[i] <= '0;
            end
        end else begin
            out_valid <= in_valid;
            out_first <= in_valid & in_first;
            if (in_valid) begin
                for (int i = 0; i < int'(LANES); i++) begin
                    prod[i] <= a_ext[i] * b_ext[i];
                end
            end
        end
    end

    // Sum of the registered products, sign-extended to the accumulator width
    always_comb begin
        sum = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            sum = sum + {{(ACC_W-2*DATA_W){prod[i][2*DATA_W-1]}}, prod[i]};
        end
    end

endmodule

// File: rtl/dot_product_mac.sv
// Pipelined signed fixed-point dot product: sum(a[i]*b[i]) + bias with
// optional ReLU and saturation, one result per streamed input vector.
module dot_product_mac
    import nn_fixed_pkg::*;
#(
    parameter int unsigned DATA_W = NN_DATA_W,
    parameter int unsigned FRAC_W = NN_FRAC_W,
    parameter int unsigned LANES  = 4,
    parameter int unsigned ACC_W  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_last,
    input  logic [LANES*DATA_W-1:0] s_a,
    input  logic [LANES*DATA_W-1:0] s_b,
    input  logic [DATA_W-1:0]       s_bias,
    input  logic                    s_relu,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_W-1:0]       m_data,
    output logic                    m_sat
);

    mac_state_t state;
    mac_state_t state_next;

    logic                     accept;
    logic                     first_pending;
    logic                     t_valid;
    logic                     t_first;
    logic signed [ACC_W-1:0]  t_sum;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  biased;
    logic signed [ACC_W-1:0]  post_q;
    logic [DATA_W-1:0]        bias_q;
    logic                     relu_q;
    sat_result_t              post_res;

    // Handshake flags depend on state (and reset) only, never on s_valid/m_ready
    assign s_ready = (state == ST_ACCUM) && !reset;
    assign m_valid = (state == ST_OUT) && !reset;
    assign accept  = s_valid && s_ready;

    mac_lane_tree #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .ACC_W  (ACC_W)
    ) u_tree (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (accept),
        .in_first  (first_pending),
        .a         (s_a),
        .b         (s_b),
        .out_valid (t_valid),
        .out_first (t_first),
        .sum       (t_sum)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // After the last beat, drain stage 1, the accumulator and post-processing
    always_comb begin
        state_next = state;
        case (state)
            ST_ACCUM:  if (accept && s_last) state_next = ST_DRAIN;
            ST_DRAIN:  state_next = ST_FLUSH1;
            ST_FLUSH1: state_next = ST_FLUSH2;
            ST_FLUSH2: state_next = ST_OUT;
            ST_OUT:    if (m_ready) state_next = ST_ACCUM;
            default:   state_next = ST_ACCUM;
        endcase
    end

    // Track whether the next accepted beat starts a new vector
    always_ff @(posedge clk) begin
        if (reset) begin
            first_pending <= 1'b1;
        end else if (accept) begin
            first_pending <= 1'b0;
        end else if (m_valid && m_ready) begin
            first_pending <= 1'b1;
        end
    end

    // Capture per-vector bias and mode with the first beat
    always_ff @(posedge clk) begin
        if (reset) begin
            bias_q <= '0;
            relu_q <= 1'b0;
        end else if (accept && first_pending) begin
            bias_q <= s_bias;
            relu_q <= s_relu;
        end
    end

    // Full-precision accumulator; a first beat loads instead of adding
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (t_valid) begin
            acc <= (t_first ? '0 : acc) + t_sum;
        end
    end

    assign bias_ext = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q};
    assign biased   = acc + (bias_ext <<< FRAC_W);

    // Register the bias-added, rescaled sum (arithmetic shift floors)
    always_ff @(posedge clk) begin
        if (reset) begin
            post_q <= '0;
        end else if (state == ST_FLUSH1) begin
            post_q <= biased >>> FRAC_W;
        end
    end

    assign post_res = sat_relu(64'(post_q), relu_q, DATA_W);

    // Result register, held stable for the whole output handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            m_data <= '0;
            m_sat  <= 1'b0;
        end else if (state == ST_FLUSH2) begin
            m_data <= DATA_W'(post_res.value);
            m_sat  <= post_res.sat;
        end
    end

endmodule

// File: tb/tb_dot_product_mac.sv
// Self-checking bench for dot_product_mac with an arithmetic reference model.
module tb_dot_product_mac;

    localparam int DW = 8;
    localparam int LN = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              s_valid;
    logic              s_ready;
    logic              s_last;
    logic [LN*DW-1:0]  s_a;
    logic [LN*DW-1:0]  s_b;
    logic [DW-1:0]     s_bias;
    logic              s_relu;
    logic              m_valid;
    logic              m_ready;
    logic [DW-1:0]     m_data;
    logic              m_sat;

    int assert_count = 0;
    int fail_count   = 0;
    int cyc          = 0;
    int last_edge    = 0;

    logic [LN*DW-1:0]  vec_a[$];
    logic [LN*DW-1:0]  vec_b[$];
    logic [DW-1:0]     vec_bias;
    logic              vec_relu;

    dot_product_mac dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_last  (s_last),
        .s_a     (s_a),
        .s_b     (s_b),
        .s_bias  (s_bias),
        .s_relu  (s_relu),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_sat   (m_sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer dot product, bias scaled by 2^6, floor divide, ReLU, clamp
    function automatic logic [8:0] modelResult();
        longint total;
        longint q;
        logic [LN*DW-1:0] aw;
        logic [LN*DW-1:0] bw;
        total = 0;
        for (int j = 0; j < vec_a.size(); j++) begin
            aw = vec_a[j];
            bw = vec_b[j];
            for (int l = 0; l < LN; l++) begin
                total += longint'($signed(aw[l*DW +: DW])) * longint'($signed(bw[l*DW +: DW]));
            end
        end
        total += longint'($signed(vec_bias)) * 64;
        q = total >>> 6;
        if (vec_relu && q < 0)  return 9'h000;
        if (q > 127)            return {1'b1, 8'h7F};
        if (q < -128)           return {1'b1, 8'h80};
        return {1'b0, 8'(q)};
    endfunction

    task automatic loadVector(input int beats);
        vec_a.delete();
        vec_b.delete();
        for (int j = 0; j < beats; j++) begin
            vec_a.push_back($urandom);
            vec_b.push_back($urandom);
        end
        vec_bias = 8'($urandom);
        vec_relu = 1'($urandom);
    endtask

    task automatic pushLane0(input logic [7:0] a, input logic [7:0] b);
        vec_a.push_back({24'h0, a});
        vec_b.push_back({24'h0, b});
    endtask

    // Stream the queued vector; bias/relu are garbage on non-first beats
    task automatic applyStimulus(input int gap_pct, input logic with_last);
        int waited;
        for (int j = 0; j < vec_a.size(); j++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                s_valid = 1'b0;
                s_a     = $urandom;
                s_b     = $urandom;
                s_last  = 1'($urandom);
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_a     = vec_a[j];
            s_b     = vec_b[j];
            s_last  = with_last && (j == vec_a.size() - 1);
            s_bias  = (j == 0) ? vec_bias : 8'($urandom);
            s_relu  = (j == 0) ? vec_relu : 1'($urandom);
            waited  = 0;
            while (s_ready !== 1'b1 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            checkOutput("beat_accept", {31'h0, s_ready}, 32'h1);
            @(posedge clk);
            @(negedge clk);
            last_edge = cyc;
            s_valid = 1'b0;
            s_a     = $urandom;
            s_b     = $urandom;
            s_last  = 1'($urandom);
        end
    endtask

    // Wait for the result, compare with the model, optionally stall, handshake
    task automatic collectResult(input int hold);
        logic [8:0] exp;
        logic [7:0] held;
        int n;
        exp = modelResult();
        n = 0;
        while (m_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("m_valid_seen", {31'h0, m_valid}, 32'h1);
        checkOutput("latency", 32'(cyc - last_edge), 32'd3);
        checkOutput("m_data", {24'h0, m_data}, {24'h0, exp[7:0]});
        checkOutput("m_sat", {31'h0, m_sat}, {31'h0, exp[8]});
        if (hold > 0) begin
            m_ready = 1'b0;
            held = m_data;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                checkOutput("hold_data", {24'h0, m_data}, {24'h0, held});
                checkOutput("hold_s_ready", {31'h0, s_ready}, 32'h0);
                checkOutput("hold_m_valid", {31'h0, m_valid}, 32'h1);
            end
            m_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput("s_ready_after", {31'h0, s_ready}, 32'h1);
        checkOutput("m_valid_drop", {31'h0, m_valid}, 32'h0);
        if (hold == 0) checkOutput("reissue", 32'(cyc - last_edge), 32'd4);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("s_ready_in_reset", {31'h0, s_ready}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic expectSilence(input string tag);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            seen = seen | m_valid;
        end
        checkOutput(tag, {31'h0, seen}, 32'h0);
    endtask

    initial begin
        int n;
        reset   = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_a     = '0;
        s_b     = '0;
        s_bias  = '0;
        s_relu  = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("s_ready_in_reset", {31'h0, s_ready}, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_s_ready", {31'h0, s_ready}, 32'h1);
        checkOutput("rst_m_valid", {31'h0, m_valid}, 32'h0);
        checkOutput("rst_m_data", {24'h0, m_data}, 32'h0);
        checkOutput("rst_m_sat", {31'h0, m_sat}, 32'h0);

        $display("[TB] three-beat single-lane vector");
        vec_a.delete(); vec_b.delete();
        pushLane0(8'h15, 8'h2A); pushLane0(8'h21, 8'h2A); pushLane0(8'h10, 8'h2A);
        vec_bias = 8'h00; vec_relu = 1'b0;
        applyStimulus(0, 1'b1);
        collectResult(0);

        $display("[TB] negative intermediate sum, relu on and off");
        vec_a.delete(); vec_b.delete();
        pushLane0(8'h0C, 8'h02); pushLane0(8'h0C, 8'hC0); pushLane0(8'h0C, 8'h7F);
        vec_bias = 8'h00; vec_relu = 1'b1;
        applyStimulus(0, 1'b1);
        collectResult(0);
        vec_relu = 1'b0;
        applyStimulus(0, 1'b1);
        collectResult(0);

        $display("[TB] saturation high, low, and relu over saturation");
        vec_a.delete(); vec_b.delete();
        for (int j = 0; j < 3; j++) pushLane0(8'h40, 8'h30);
        vec_bias = 8'h00; vec_relu = 1'b0;
        applyStimulus(0, 1'b1);
        collectResult(0);
        checkOutput("sat_hi_data", {24'h0, m_data}, 32'h7F);
        vec_a.delete(); vec_b.delete();
        for (int j = 0; j < 3; j++) pushLane0(8'h40, 8'h80);
        applyStimulus(0, 1'b1);
        collectResult(0);
        checkOutput("sat_lo_data", {24'h0, m_data}, 32'h80);
        vec_relu = 1'b1;
        applyStimulus(0, 1'b1);
        collectResult(0);
        checkOutput("relu_data", {24'h0, m_data}, 32'h00);

        $display("[TB] four-lane one-beat vector with backpressure");
        vec_a.delete(); vec_b.delete();
        vec_a.push_back(32'h40404040);
        vec_b.push_back(32'h08081010);
        vec_bias = 8'hF0; vec_relu = 1'b0;
        applyStimulus(0, 1'b1);
        collectResult(5);
        checkOutput("four_lane_data", {24'h0, m_data}, 32'h20);

        $display("[TB] random vectors with input gaps");
        for (int v = 0; v < 12; v++) begin
            loadVector(1 + int'($urandom_range(4)));
            applyStimulus(30, 1'b1);
            collectResult(0);
        end

        $display("[TB] reset mid-vector");
        loadVector(2);
        applyStimulus(0, 1'b0);
        pulseReset();
        expectSilence("no_valid_after_mid_reset");
        loadVector(3);
        applyStimulus(10, 1'b1);
        collectResult(0);

        $display("[TB] reset while result pending");
        loadVector(2);
        m_ready = 1'b0;
        applyStimulus(0, 1'b1);
        n = 0;
        while (m_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("out_reached", {31'h0, m_valid}, 32'h1);
        pulseReset();
        m_ready = 1'b1;
        expectSilence("no_valid_after_out_reset");
        loadVector(2);
        applyStimulus(0, 1'b1);
        collectResult(0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
